// File: rtl/multiplexer_nto1_stream.sv
// N-to-1 streaming multiplexer with a registered output stage.
// Mode 0 forwards the channel picked by sel; mode 1 arbitrates round-robin
// among valid channels, starting the search just past the last winner.
module multiplexer_nto1_stream #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    r_data;
    logic [SEL_W-1:0]    r_chan;
    logic                r_valid;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_load_en;
    logic [CHANNELS-1:0] w_rot;
    logic                w_rr_vld;
    logic [SEL_W-1:0]    w_rr_idx;
    logic                w_sel_vld;
    logic                w_grant_vld;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [WIDTH-1:0]    w_grant_data;

    // Modular add on channel indices, wrapping at CHANNELS (not at 2**SEL_W).
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= CHANNELS) s = s - CHANNELS;
        return SEL_W'(s);
    endfunction

    // Output register can take a new word when empty or being drained.
    assign w_load_en = !r_valid || out_ready;

    // Valid vector rotated so bit 0 is the channel at the round-robin pointer.
    assign w_rot = CHANNELS'({in_valid, in_valid} >> r_ptr);

    // Round-robin search: lowest rotated position wins, mapped back to a channel.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_idx = '0;
        for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_rr_vld = 1'b1;
                w_rr_idx = wrap_add(r_ptr, 32'(k));
            end
        end
    end

    // Fixed-select request; an out-of-range sel matches no channel.
    always_comb begin
        w_sel_vld = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (sel == SEL_W'(i)) w_sel_vld = in_valid[i];
        end
    end

    // Pick the grant source according to mode.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        if (mode) begin
            w_grant_vld = w_rr_vld;
            w_grant_idx = w_rr_idx;
        end else begin
            w_grant_vld = w_sel_vld;
            w_grant_idx = sel;
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (w_grant_idx == SEL_W'(i)) w_grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // One-hot ready toward the granted channel; forced low during reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            in_ready[i] = rst_n && w_load_en && w_grant_vld && (w_grant_idx == SEL_W'(i));
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_ptr   <= '0;
        end else if (w_load_en) begin
            if (w_grant_vld) begin
                r_valid <= 1'b1;
                r_data  <= w_grant_data;
                r_chan  <= w_grant_idx;
                if (mode) r_ptr <= wrap_add(w_grant_idx, 32'd1);
            end else begin
                // Data and channel hold; only valid drops.
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_chan  = r_chan;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_multiplexer_nto1_stream.sv
// Bench for multiplexer_nto1_stream: a 4x8 and an 8x16 instance run side by
// side against a transaction-level model of grant, output register and pointer.
module tb_multiplexer_nto1_stream;

    logic        clk;
    logic        rst_n;

    logic [31:0]  a_in_data;
    logic [3:0]   a_in_valid, a_in_ready;
    logic         a_mode, a_out_valid, a_out_ready;
    logic [1:0]   a_sel, a_out_chan;
    logic [7:0]   a_out_data;

    logic [127:0] b_in_data;
    logic [7:0]   b_in_valid, b_in_ready;
    logic         b_mode, b_out_valid, b_out_ready;
    logic [2:0]   b_sel, b_out_chan;
    logic [15:0]  b_out_data;

    // Stimulus per instance (index 0 = 4-channel, 1 = 8-channel)
    logic [15:0] s_data [2][8];
    logic [7:0]  s_valid [2];
    logic        s_mode [2];
    logic [2:0]  s_sel [2];
    logic        s_ordy [2];

    // Reference model state
    bit          m_valid [2];
    int unsigned m_data [2];
    int unsigned m_chan [2];
    int unsigned m_ptr [2];

    int checks;
    int errors;

    multiplexer_nto1_stream u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .mode      (a_mode),
        .sel       (a_sel),
        .out_data  (a_out_data),
        .out_chan  (a_out_chan),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready)
    );

    multiplexer_nto1_stream #(
        .WIDTH    (16),
        .CHANNELS (8),
        .SEL_W    (3)
    ) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .mode      (b_mode),
        .sel       (b_sel),
        .out_data  (b_out_data),
        .out_chan  (b_out_chan),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) a_in_data[i*8 +: 8] = s_data[0][i][7:0];
        for (int i = 0; i < 8; i++) b_in_data[i*16 +: 16] = s_data[1][i];
        a_in_valid  = s_valid[0][3:0];
        a_mode      = s_mode[0];
        a_sel       = s_sel[0][1:0];
        a_out_ready = s_ordy[0];
        b_in_valid  = s_valid[1];
        b_mode      = s_mode[1];
        b_sel       = s_sel[1];
        b_out_ready = s_ordy[1];
    end

    function automatic int unsigned nch(input int d);
        return (d != 0) ? 8 : 4;
    endfunction

    function automatic logic [31:0] obs_ready(input int d);
        return (d != 0) ? 32'(b_in_ready) : 32'(a_in_ready);
    endfunction

    function automatic logic [31:0] obs_valid(input int d);
        return (d != 0) ? 32'(b_out_valid) : 32'(a_out_valid);
    endfunction

    function automatic logic [31:0] obs_data(input int d);
        return (d != 0) ? 32'(b_out_data) : 32'(a_out_data);
    endfunction

    function automatic logic [31:0] obs_chan(input int d);
        return (d != 0) ? 32'(b_out_chan) : 32'(a_out_chan);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = 0;
            m_chan[d]  = 0;
            m_ptr[d]   = 0;
        end
    endtask

    // Who should win this cycle: the selected channel, or the first valid one
    // in the circular order ptr, ptr+1, ...
    task automatic model_grant(input int d, output bit gv, output int unsigned g);
        int unsigned n;
        n  = nch(d);
        gv = 1'b0;
        g  = 0;
        if (!s_mode[d]) begin
            g  = 32'(s_sel[d]);
            gv = (g < n) && s_valid[d][g];
        end else begin
            for (int unsigned k = 0; k < n; k++) begin
                int unsigned c;
                c = (m_ptr[d] + k) % n;
                if (!gv && s_valid[d][c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
    endtask

    task automatic chk_outputs(input int d);
        chk($sformatf("out_valid[%0d]", d), obs_valid(d), 32'(m_valid[d]));
        chk($sformatf("out_data[%0d]", d), obs_data(d), m_data[d]);
        chk($sformatf("out_chan[%0d]", d), obs_chan(d), m_chan[d]);
    endtask

    // One clock: check ready against the model, cross the edge, check outputs.
    // Entered shortly after a rising edge with the inputs already applied.
    task automatic tick();
        bit          gv [2];
        int unsigned g [2];
        bit          ld [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            model_grant(d, gv[d], g[d]);
            ld[d] = !m_valid[d] || s_ordy[d];
            chk($sformatf("in_ready[%0d]", d), obs_ready(d),
                (ld[d] && gv[d]) ? (32'd1 << g[d]) : 32'd0);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (ld[d]) begin
                if (gv[d]) begin
                    m_valid[d] = 1'b1;
                    m_data[d]  = (d != 0) ? 32'(s_data[d][g[d]]) : 32'(s_data[d][g[d]][7:0]);
                    m_chan[d]  = g[d];
                    if (s_mode[d]) m_ptr[d] = (g[d] + 1) % nch(d);
                end else begin
                    m_valid[d] = 1'b0;
                end
            end
            chk_outputs(d);
        end
    endtask

    task automatic set_chan(input int d, input logic [7:0] mask, input logic [15:0] base);
        s_valid[d] = mask;
        for (int i = 0; i < 8; i++) s_data[d][i] = base + 16'(i);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            set_chan(d, 8'h00, 16'h0000);
            s_mode[d] = 1'b0;
            s_sel[d]  = 3'd0;
            s_ordy[d] = 1'b1;
        end
        model_reset();

        // Reset: ready gated low even with requests present
        s_valid[0] = 8'h0f;
        s_mode[0]  = 1'b1;
        #12;
        chk("rst_in_ready_a", 32'(a_in_ready), 32'd0);
        chk_outputs(0);
        chk_outputs(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fixed select
        s_mode[0] = 1'b0;
        s_sel[0]  = 3'd2;
        set_chan(0, 8'b0100, 16'h0000);
        s_data[0][2] = 16'h00A5;
        #1;
        chk("t1_in_ready", 32'(a_in_ready), 32'b0100);
        tick();
        chk("t1_out_valid", 32'(a_out_valid), 32'd1);
        chk("t1_out_data", 32'(a_out_data), 32'hA5);
        chk("t1_out_chan", 32'(a_out_chan), 32'd2);
        s_sel[0] = 3'd1;
        tick();
        chk("t1_drain", 32'(a_out_valid), 32'd0);

        // Round-robin, all valid
        s_mode[0] = 1'b1;
        set_chan(0, 8'h0f, 16'h0010);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_chan", 32'(a_out_chan), 32'(k % 4));
            chk("t2_data", 32'(a_out_data), 32'h10 + 32'(k % 4));
            chk("t2_valid", 32'(a_out_valid), 32'd1);
        end

        // Sparse round-robin
        s_valid[0] = 8'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_chan", 32'(a_out_chan), (k % 2 != 0) ? 32'd3 : 32'd1);
        end

        // Backpressure
        s_mode[0] = 1'b0;
        s_sel[0]  = 3'd0;
        set_chan(0, 8'b0001, 16'h0000);
        s_data[0][0] = 16'h003C;
        tick();
        chk("t4_load", 32'(a_out_data), 32'h3C);
        s_data[0][0] = 16'h003D;
        s_ordy[0]    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_hold_data", 32'(a_out_data), 32'h3C);
            chk("t4_hold_ready", 32'(a_in_ready), 32'd0);
        end
        s_ordy[0] = 1'b1;
        tick();
        chk("t4_release", 32'(a_out_data), 32'h3D);

        // Reset mid-stream with ptr at 2
        s_mode[0] = 1'b1;
        set_chan(0, 8'b0010, 16'h0055);
        tick();
        chk("t5_pre_valid", 32'(a_out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_async_valid", 32'(a_out_valid), 32'd0);
        chk("t5_async_data", 32'(a_out_data), 32'd0);
        chk("t5_async_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_chan(0, 8'h0f, 16'h0020);
        tick();
        chk("t5_first_grant", 32'(a_out_chan), 32'd0);
        chk("t5_first_data", 32'(a_out_data), 32'h20);

        // Wide instance: fixed select of the top channel, then pointer wrap
        s_mode[1] = 1'b0;
        s_sel[1]  = 3'd7;
        set_chan(1, 8'h80, 16'h0000);
        s_data[1][7] = 16'hBEEF;
        tick();
        chk("t6_data", 32'(b_out_data), 32'hBEEF);
        chk("t6_chan", 32'(b_out_chan), 32'd7);
        s_mode[1] = 1'b1;
        set_chan(1, 8'hff, 16'hB000);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t6_rr_chan", 32'(b_out_chan), 32'(k % 8));
            chk("t6_rr_data", 32'(b_out_data), 32'hB000 + 32'(k % 8));
        end

        // Random traffic on both instances
        for (int t = 0; t < 400; t++) begin
            for (int d = 0; d < 2; d++) begin
                s_valid[d] = 8'($urandom) & ((d != 0) ? 8'hff : 8'h0f);
                s_mode[d]  = 1'($urandom);
                s_sel[d]   = 3'($urandom % nch(d));
                s_ordy[d]  = ($urandom % 4) != 0;
                for (int i = 0; i < 8; i++) begin
                    s_data[d][i] = 16'($urandom) & ((d != 0) ? 16'hffff : 16'h00ff);
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplexer_nto1_stream.md
Name: multiplexer_nto1_stream

Overview:
- Parametrised N-to-1 streaming multiplexer with a registered output and valid/ready handshakes on every input channel and on the output.
- Two selection modes: fixed select (mode 0), where an external select picks the channel, and round-robin arbitration (mode 1) among channels that are presenting valid data.
- Sits between multiple producers and a single consumer, and replaces ad-hoc combinational muxes wherever backpressure or fair sharing is required.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels; legal range ≥2.
- SEL_W, 2, select/index width; must equal clog2(CHANNELS).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational, at most one bit high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in mode 0; ignored in mode 1.
- out_data  output  WIDTH  registered output data.
- out_chan  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0. While in reset, in_ready=0.
- load_en = !out_valid || out_ready. The output register accepts new data only when load_en=1.
- Grant, mode 0: grant valid iff sel < CHANNELS and in_valid[sel]=1; grant index = sel. If sel ≥ CHANNELS (out-of-range), there is never a grant and the output drains to invalid.
- Grant, mode 1: the first i with in_valid[i]=1, searching ptr, ptr+1, … with wrap modulo CHANNELS. No grant if in_valid is all zero.
- in_ready[g] = load_en && grant valid, where g is the grant index. All other in_ready bits are 0.
- A channel transfer occurs when in_valid[g] && in_ready[g].
- Transfer cycle, next edge: out_data <= channel g data; out_chan <= g; out_valid <= 1.
- Pointer update: in mode 1 only, ptr <= g+1, wrapping to 0 when g = CHANNELS-1. Mode 0 transfers leave ptr unchanged.
- load_en=1 with no grant: out_valid <= 0. out_data and out_chan hold their previous values (don't-care to the consumer).
- Backpressure (out_valid=1, out_ready=0): out_data, out_chan and out_valid are held stable, and all in_ready=0. No data is dropped or duplicated.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle while out_ready=1 and a grant exists.
- Simultaneous drain and load (out_valid=1, out_ready=1, grant present): the old word is consumed and the new word is loaded on the same edge, with no bubble.
- mode or sel change: takes effect combinationally on the current cycle's grant. A word already registered is unaffected.
- Fairness, mode 1: with all channels continuously valid and out_ready=1, the grant sequence is 0,1,…,CHANNELS-1,0,…. No channel waits more than CHANNELS-1 transfers.
- Reset asserted mid-stream: the registered word is discarded immediately (out_valid=0 asynchronously) and ptr returns to 0.
- Input-side requirement: a producer must hold data stable while valid=1 and ready=0. The block does not check this.

Test Plan:
1. Fixed select, default params:
   - Stimulus: mode=0, sel=2, ch2 data=8'hA5, valid on ch2 only, out_ready=1.
   - Response: in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_chan=2.
   - Then sel=1 with ch1 invalid → out_valid drops to 0 after one cycle.
2. Round-robin:
   - Stimulus: mode=1, all four channels valid with data 8'h10,8'h11,8'h12,8'h13, out_ready=1 for 8 cycles.
   - Response: out_chan sequence 0,1,2,3,0,1,2,3 and out_data sequence 10,11,12,13,10,… every cycle, with no bubbles.
3. Sparse round-robin:
   - Stimulus: mode=1, ptr=0, only ch1 and ch3 valid.
   - Response: grants alternate 1,3,1,3. ch0 and ch2 in_ready stay 0.
4. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles after out_valid rises with data 8'h3C.
   - Response: out_data stays 8'h3C, out_chan is stable, and all in_ready=0 for those 3 cycles.
   - On release, the next word follows on the following edge.
5. Reset mid-stream:
   - Stimulus: pull rst_n low between edges while out_valid=1 in mode 1 with ptr=2.
   - Response: out_valid=0 and out_data=0 immediately. After release with all channels valid, the first grant is ch0.
6. Parametrised instance WIDTH=16, CHANNELS=8, SEL_W=3:
   - Stimulus: mode=0, sel=7, ch7 data=16'hBEEF.
   - Response: out_data=16'hBEEF, out_chan=7. Repeat test 2 and confirm the round-robin pointer wraps from 7 to 0.
